cmd_sched: RTL and testbench

- Round-robin scheduler that shares one Wishbone master bus among NUM_REQ queued command slots, e.g. 2 cores x {i,d} queue entries.
- Grants one valid slot at a time and drives the single-beat WB transaction.
- Returns cmd_taken/cmd_complete pulses to the owning command queue, plus a response (read data or error) tagged with the slot index.
- Sits between the per-core command queues and the node's external WB bus.

---
 rtl/cmd_sched.sv | 220 ++++++++++++++++++++++
 tb/tb_cmd_sched.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_sched.sv
// ---------------------------------------------------------------------------
// cmd_sched
//   Round-robin scheduler that shares one single-beat Wishbone master bus
//   among NUM_REQ queued command slots. One transaction is outstanding at a
//   time. The owning queue receives a cmd_taken pulse when its slot is
//   granted. When the transaction ends it receives a cmd_complete pulse and a
//   tagged response: read data, error or timeout.
//
// Ports
//   clk, rst        : clock; asynchronous active-low reset
//   req_valid/we    : per-slot command valid / write enable (NUM_REQ bits)
//   req_sel         : per-slot byte selects, slot i at [4i+3:4i]
//   req_adr/datw    : per-slot address / write data, slot i at [32i+31:32i]
//   cmd_taken       : one-hot pulse, slot granted onto the bus
//   cmd_complete    : one-hot pulse, slot transaction finished
//   wb_*            : Wishbone master (cyc/stb/we/sel/adr/datw out,
//                     ack/err/datr in)
//   rsp_valid/id    : response pulse and slot index
//   rsp_err/data    : error-or-timeout flag, read data (0 for writes/errors)
// ---------------------------------------------------------------------------
module cmd_sched #(
  parameter int NUM_REQ = 4,
  parameter int REQ_W   = 2,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_we,
  input  logic [4*NUM_REQ-1:0]  req_sel,
  input  logic [32*NUM_REQ-1:0] req_adr,
  input  logic [32*NUM_REQ-1:0] req_datw,
  output logic [NUM_REQ-1:0]    cmd_taken,
  output logic [NUM_REQ-1:0]    cmd_complete,
  output logic                  wb_cyc,
  output logic                  wb_stb,
  output logic                  wb_we,
  output logic [3:0]            wb_sel,
  output logic [31:0]           wb_adr,
  output logic [31:0]           wb_datw,
  input  logic                  wb_ack,
  input  logic                  wb_err,
  input  logic [31:0]           wb_datr,
  output logic                  rsp_valid,
  output logic [REQ_W-1:0]      rsp_id,
  output logic                  rsp_err,
  output logic [31:0]           rsp_data
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Timeout fires on the edge where the counter would reach TIMEOUT.
  localparam bit              TO_EN   = (TIMEOUT != 0) ? 1'b1 : 1'b0;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  state_e               state_q, state_d;
  logic [REQ_W-1:0]     ptr_q, ptr_d;
  logic [TO_W-1:0]      cnt_q, cnt_d;
  logic                 wb_cyc_q, wb_cyc_d;
  logic                 wb_stb_q, wb_stb_d;
  logic                 wb_we_q, wb_we_d;
  logic [3:0]           wb_sel_q, wb_sel_d;
  logic [31:0]          wb_adr_q, wb_adr_d;
  logic [31:0]          wb_datw_q, wb_datw_d;
  logic [NUM_REQ-1:0]   cmd_taken_q, cmd_taken_d;
  logic [NUM_REQ-1:0]   cmd_complete_q, cmd_complete_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [REQ_W-1:0]     rsp_id_q, rsp_id_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [31:0]          rsp_data_q, rsp_data_d;

  logic                 gnt_found_s;
  logic [REQ_W-1:0]     gnt_idx_s;

  // Round-robin pick: first valid slot scanning from ptr+1 with wrap-around.
  always_comb begin : rr_pick
    logic [REQ_W-1:0] cand;
    cand        = '0;
    gnt_found_s = 1'b0;
    gnt_idx_s   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = REQ_W'((int'(ptr_q) + i) % NUM_REQ);
      if (!gnt_found_s && req_valid[cand]) begin
        gnt_found_s = 1'b1;
        gnt_idx_s   = cand;
      end else begin
        gnt_found_s = gnt_found_s;
      end
    end
  end

  // Next-state and next-output logic for the IDLE -> BUS -> DONE sequence.
  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    cnt_d          = cnt_q;
    wb_cyc_d       = wb_cyc_q;
    wb_stb_d       = wb_stb_q;
    wb_we_d        = wb_we_q;
    wb_sel_d       = wb_sel_q;
    wb_adr_d       = wb_adr_q;
    wb_datw_d      = wb_datw_q;
    cmd_taken_d    = '0;
    cmd_complete_d = '0;
    rsp_valid_d    = 1'b0;
    rsp_id_d       = rsp_id_q;
    rsp_err_d      = rsp_err_q;
    rsp_data_d     = rsp_data_q;

    case (state_q)
      ST_IDLE: begin
        if (gnt_found_s) begin
          wb_cyc_d               = 1'b1;
          wb_stb_d               = 1'b1;
          wb_we_d                = req_we[gnt_idx_s];
          wb_sel_d               = req_sel[int'(gnt_idx_s)*4 +: 4];
          wb_adr_d               = req_adr[int'(gnt_idx_s)*32 +: 32];
          wb_datw_d              = req_datw[int'(gnt_idx_s)*32 +: 32];
          cmd_taken_d[gnt_idx_s] = 1'b1;
          ptr_d                  = gnt_idx_s;
          rsp_id_d               = gnt_idx_s;
          cnt_d                  = '0;
          state_d                = ST_BUS;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_BUS: begin
        // Ack has priority over err and over a simultaneous timeout.
        if (wb_ack) begin
          wb_cyc_d                 = 1'b0;
          wb_stb_d                 = 1'b0;
          cmd_complete_d[rsp_id_q] = 1'b1;
          rsp_valid_d              = 1'b1;
          rsp_err_d                = 1'b0;
          rsp_data_d               = wb_we_q ? 32'h0000_0000 : wb_datr;
          state_d                  = ST_DONE;
        end else if (wb_err || (TO_EN && (cnt_q == TO_LAST))) begin
          wb_cyc_d                 = 1'b0;
          wb_stb_d                 = 1'b0;
          cmd_complete_d[rsp_id_q] = 1'b1;
          rsp_valid_d              = 1'b1;
          rsp_err_d                = 1'b1;
          rsp_data_d               = 32'h0000_0000;
          state_d                  = ST_DONE;
        end else begin
          cnt_d = cnt_q + {{(TO_W-1){1'b0}}, 1'b1};
        end
      end

      // Turnaround: the queue clears its valid this cycle, so no grant here.
      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d  = ST_IDLE;
        wb_cyc_d = 1'b0;
        wb_stb_d = 1'b0;
      end
    endcase
  end

  // State and output registers; asynchronous reset clears all outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      ptr_q          <= REQ_W'(NUM_REQ - 1);
      cnt_q          <= '0;
      wb_cyc_q       <= 1'b0;
      wb_stb_q       <= 1'b0;
      wb_we_q        <= 1'b0;
      wb_sel_q       <= 4'h0;
      wb_adr_q       <= 32'h0000_0000;
      wb_datw_q      <= 32'h0000_0000;
      cmd_taken_q    <= '0;
      cmd_complete_q <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_id_q       <= '0;
      rsp_err_q      <= 1'b0;
      rsp_data_q     <= 32'h0000_0000;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      cnt_q          <= cnt_d;
      wb_cyc_q       <= wb_cyc_d;
      wb_stb_q       <= wb_stb_d;
      wb_we_q        <= wb_we_d;
      wb_sel_q       <= wb_sel_d;
      wb_adr_q       <= wb_adr_d;
      wb_datw_q      <= wb_datw_d;
      cmd_taken_q    <= cmd_taken_d;
      cmd_complete_q <= cmd_complete_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_id_q       <= rsp_id_d;
      rsp_err_q      <= rsp_err_d;
      rsp_data_q     <= rsp_data_d;
    end
  end

  assign cmd_taken    = cmd_taken_q;
  assign cmd_complete = cmd_complete_q;
  assign wb_cyc       = wb_cyc_q;
  assign wb_stb       = wb_stb_q;
  assign wb_we        = wb_we_q;
  assign wb_sel       = wb_sel_q;
  assign wb_adr       = wb_adr_q;
  assign wb_datw      = wb_datw_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_err      = rsp_err_q;
  assign rsp_data     = rsp_data_q;

endmodule

// File: tb/tb_cmd_sched.sv
// ---------------------------------------------------------------------------
// tb_cmd_sched
//   Table-driven bench for cmd_sched (4 slots, TIMEOUT=4): single
//   transactions from a vector table, plus hand-written sequences for reset,
//   reset mid-transaction and round-robin back-to-back grants.
// ---------------------------------------------------------------------------
module tb_cmd_sched;

  localparam int NUM_REQ = 4;
  localparam int REQ_W   = 2;
  localparam int TIMEOUT = 4;
  localparam int TO_W    = 8;

  logic                  clk;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_we;
  logic [4*NUM_REQ-1:0]  req_sel;
  logic [32*NUM_REQ-1:0] req_adr;
  logic [32*NUM_REQ-1:0] req_datw;
  logic [NUM_REQ-1:0]    cmd_taken;
  logic [NUM_REQ-1:0]    cmd_complete;
  logic                  wb_cyc, wb_stb, wb_we;
  logic [3:0]            wb_sel;
  logic [31:0]           wb_adr, wb_datw;
  logic                  wb_ack, wb_err;
  logic [31:0]           wb_datr;
  logic                  rsp_valid;
  logic [REQ_W-1:0]      rsp_id;
  logic                  rsp_err;
  logic [31:0]           rsp_data;

  cmd_sched #(
    .NUM_REQ (NUM_REQ),
    .REQ_W   (REQ_W),
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_sel      (req_sel),
    .req_adr      (req_adr),
    .req_datw     (req_datw),
    .cmd_taken    (cmd_taken),
    .cmd_complete (cmd_complete),
    .wb_cyc       (wb_cyc),
    .wb_stb       (wb_stb),
    .wb_we        (wb_we),
    .wb_sel       (wb_sel),
    .wb_adr       (wb_adr),
    .wb_datw      (wb_datw),
    .wb_ack       (wb_ack),
    .wb_err       (wb_err),
    .wb_datr      (wb_datr),
    .rsp_valid    (rsp_valid),
    .rsp_id       (rsp_id),
    .rsp_err      (rsp_err),
    .rsp_data     (rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kind: 0 = no response (timeout), 1 = ack, 2 = err, 3 = ack+err
  typedef struct {
    logic [1:0]  slot;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] datw;
    int          dly;
    logic [1:0]  kind;
    logic [31:0] datr;
    logic [3:0]  exp_taken;
    logic        exp_err;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [7];
  int   n_checks;
  int   n_fail;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] all_outs();
    return {13'd0, wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_datw, cmd_taken,
            cmd_complete, rsp_valid, rsp_id, rsp_err, rsp_data};
  endfunction

  // Non-granted slots carry junk so a wrong slot mux shows up in wb_*.
  task automatic fill_junk();
    for (int k = 0; k < NUM_REQ; k++) begin
      req_we[k]             = 1'b1;
      req_sel[k*4 +: 4]     = 4'hA;
      req_adr[k*32 +: 32]   = 32'hBAD0_0000 | 32'(k);
      req_datw[k*32 +: 32]  = 32'hC0DE_0000 | 32'(k);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    fill_junk();
    req_we[v.slot]                = v.we;
    req_sel[int'(v.slot)*4 +: 4]  = v.sel;
    req_adr[int'(v.slot)*32 +: 32]  = v.adr;
    req_datw[int'(v.slot)*32 +: 32] = v.datw;
    req_valid = 4'b0001 << v.slot;
    @(negedge clk);
    chk({tag, "_taken"}, 128'(cmd_taken), 128'(v.exp_taken));
    chk({tag, "_cyc_stb"}, 128'({wb_cyc, wb_stb}), 128'(2'b11));
    chk({tag, "_wb_fields"}, {59'd0, wb_we, wb_sel, wb_adr, wb_datw},
        {59'd0, v.we, v.sel, v.adr, v.datw});
    // Dropping valid while granted must not abort the transaction.
    req_valid = 4'b0000;
    for (int j = 1; j <= v.dly; j++) begin
      if (j == v.dly) begin
        wb_ack  = v.kind[0];
        wb_err  = v.kind[1];
        wb_datr = v.datr;
      end
      @(negedge clk);
      if (j < v.dly) begin
        chk({tag, "_hold"}, {62'd0, wb_cyc, wb_stb, cmd_taken, cmd_complete, wb_adr, wb_datw},
            {62'd0, 2'b11, 4'b0000, 4'b0000, v.adr, v.datw});
      end
    end
    wb_ack  = 1'b0;
    wb_err  = 1'b0;
    wb_datr = 32'h0000_0000;
    chk({tag, "_cyc_drop"}, 128'({wb_cyc, wb_stb}), 128'(2'b00));
    chk({tag, "_complete"}, 128'({cmd_complete, cmd_taken}), 128'({v.exp_taken, 4'b0000}));
    chk({tag, "_rsp"}, {90'd0, rsp_valid, rsp_id, rsp_err, rsp_data},
        {90'd0, 1'b1, v.slot, v.exp_err, v.exp_data});
    @(negedge clk);
    chk({tag, "_pulse_end"}, 128'({rsp_valid, cmd_complete, wb_cyc}), 128'(6'b0));
  endtask

  initial begin
    logic [3:0] rr_order [5];
    int         ng;
    int         t;
    int         last_t;
    logic [1:0] exp_id;

    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b0;
    req_valid = '0;
    req_we    = '0;
    req_sel   = '0;
    req_adr   = '0;
    req_datw  = '0;
    wb_ack    = 1'b0;
    wb_err    = 1'b0;
    wb_datr   = 32'h0000_0000;

    //                slot   we    sel    adr            datw           dly kind   datr           taken    err   data
    vecs[0] = '{2'd2, 1'b0, 4'hF, 32'h1000_0040, 32'h0000_0000, 3, 2'd1, 32'hDEAD_BEEF, 4'b0100, 1'b0, 32'hDEAD_BEEF};
    vecs[1] = '{2'd1, 1'b1, 4'h3, 32'h2000_0004, 32'h1234_5678, 1, 2'd1, 32'hFFFF_FFFF, 4'b0010, 1'b0, 32'h0000_0000};
    vecs[2] = '{2'd3, 1'b0, 4'hF, 32'h3000_0000, 32'h0000_0000, 2, 2'd2, 32'hAAAA_5555, 4'b1000, 1'b1, 32'h0000_0000};
    vecs[3] = '{2'd0, 1'b0, 4'hC, 32'h4000_0010, 32'h0000_0000, 1, 2'd3, 32'h0BAD_F00D, 4'b0001, 1'b0, 32'h0BAD_F00D};
    vecs[4] = '{2'd2, 1'b0, 4'hF, 32'h5000_0020, 32'h0000_0000, 4, 2'd0, 32'h7777_7777, 4'b0100, 1'b1, 32'h0000_0000};
    vecs[5] = '{2'd1, 1'b0, 4'h1, 32'h6000_0008, 32'h0000_0000, 4, 2'd1, 32'h5A5A_0001, 4'b0010, 1'b0, 32'h5A5A_0001};
    vecs[6] = '{2'd0, 1'b1, 4'h8, 32'h7000_000C, 32'hCAFE_F00D, 2, 2'd2, 32'h1111_2222, 4'b0001, 1'b1, 32'h0000_0000};

    // Reset state, visible before any clock edge and while held.
    #3;
    chk("reset_outs_async", all_outs(), 128'd0);
    @(negedge clk);
    @(negedge clk);
    chk("reset_outs_held", all_outs(), 128'd0);
    rst = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], i);
    end

    // Reset in the middle of a bus cycle.
    @(negedge clk);
    fill_junk();
    req_valid = 4'b0100;
    @(negedge clk);
    chk("mid_rst_granted", 128'({wb_cyc, cmd_taken}), 128'({1'b1, 4'b0100}));
    req_valid = 4'b0000;
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_outs_async", all_outs(), 128'd0);
    wb_ack = 1'b1;
    @(negedge clk);
    chk("mid_rst_outs_held", all_outs(), 128'd0);
    wb_ack = 1'b0;
    rst    = 1'b1;
    @(negedge clk);
    chk("mid_rst_no_rsp", 128'({rsp_valid, cmd_complete, wb_cyc}), 128'(6'b0));

    // Round robin: all slots continuously valid, ack held high (immediate).
    rr_order[0] = 4'b0001;
    rr_order[1] = 4'b0010;
    rr_order[2] = 4'b0100;
    rr_order[3] = 4'b1000;
    rr_order[4] = 4'b0001;
    req_valid = 4'b1111;
    wb_ack    = 1'b1;
    wb_datr   = 32'h0000_0000;
    ng        = 0;
    t         = 0;
    last_t    = 0;
    exp_id    = 2'd0;
    while (ng < 5 && t < 60) begin
      @(negedge clk);
      t++;
      if (rsp_valid) begin
        chk("rr_rsp_id", 128'({rsp_id, rsp_err}), 128'({exp_id, 1'b0}));
      end
      if (cmd_taken != 4'b0000) begin
        chk($sformatf("rr_grant%0d", ng), 128'({cmd_taken, wb_cyc}), 128'({rr_order[ng], 1'b1}));
        if (ng > 0) begin
          chk($sformatf("rr_gap%0d", ng), 128'(t - last_t), 128'(3));
        end
        last_t = t;
        exp_id = 2'(ng % 4);
        ng++;
      end
    end
    chk("rr_grant_count", 128'(ng), 128'(5));
    req_valid = 4'b0000;
    wb_ack    = 1'b0;
    repeat (4) @(negedge clk);
    chk("final_idle", 128'({wb_cyc, wb_stb}), 128'(2'b00));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
